// File: rtl/ldpc_pkg.sv
//------------------------------------------------------------------------------
// Module   : ldpc_pkg
// Purpose  : Shared constants and FSM state type for the LDPC frame
//            sequencer around the 4320/360 parity encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ldpc_pkg;

  localparam int K_INFO     = 4320;            // information bits per frame
  localparam int N_PAR      = 360;             // parity bits per frame
  localparam int GROUP      = 360;             // encoder column-group size
  localparam int CLR_CYCLES = 3;               // encoder clear/prime cycles
  localparam int CW_LEN     = K_INFO + N_PAR;  // codeword length

  typedef enum logic [1:0] {
    CLR   = 2'd0,
    INFO  = 2'd1,
    FLUSH = 2'd2,
    PAR   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ldpc_frame_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : ldpc_frame_ctrl_if
// Purpose  : Bundles the source stream, encoder control/return path and the
//            codeword output stream of the LDPC frame sequencer.
//            slave  = frame-sequencer view, master = environment view.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ldpc_frame_ctrl_if;

  logic        s_valid;
  logic        s_data;
  logic        s_ready;
  logic        enc_rst_n;
  logic        enc_din_valid;
  logic        enc_din;
  logic [12:0] enc_counter;
  logic [8:0]  enc_out_addr;
  logic        enc_check;
  logic        enc_dout;
  logic        m_valid;
  logic        m_data;
  logic        m_sof;
  logic        m_eof;

  modport slave (
    input  s_valid, s_data, enc_dout,
    output s_ready, enc_rst_n, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_check, m_valid, m_data, m_sof, m_eof
  );

  modport master (
    output s_valid, s_data, enc_dout,
    input  s_ready, enc_rst_n, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_check, m_valid, m_data, m_sof, m_eof
  );

endinterface

`default_nettype wire

// File: rtl/ldpc_out_pipe.sv
//------------------------------------------------------------------------------
// Module   : ldpc_out_pipe
// Purpose  : Two-stage alignment pipe. Systematic bits are delayed two
//            cycles; parity slots wait one cycle for the encoder's registered
//            output and then register it, so both bit types leave with the
//            same latency and in issue order.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ldpc_out_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic slot_valid_i,
  input  logic sys_bit_i,
  input  logic par_sel_i,
  input  logic sof_i,
  input  logic eof_i,
  input  logic enc_dout_i,
  output logic m_valid_o,
  output logic m_data_o,
  output logic m_sof_o,
  output logic m_eof_o
);

  logic v1_q, sys1_q, psel1_q, sof1_q, eof1_q;
  logic v2_q, data2_q, sof2_q, eof2_q;

  // Stage 1: capture the slot descriptor in the cycle the encoder sees the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sys1_q  <= 1'b0;
      psel1_q <= 1'b0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
    end else begin
      v1_q    <= slot_valid_i;
      sys1_q  <= sys_bit_i;
      psel1_q <= par_sel_i;
      sof1_q  <= sof_i;
      eof1_q  <= eof_i;
    end
  end

  // Stage 2: merge the encoder's parity bit (valid now) with systematic data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      data2_q <= 1'b0;
      sof2_q  <= 1'b0;
      eof2_q  <= 1'b0;
    end else begin
      v2_q    <= v1_q;
      data2_q <= v1_q & (psel1_q ? enc_dout_i : sys1_q);
      sof2_q  <= v1_q & sof1_q;
      eof2_q  <= v1_q & eof1_q;
    end
  end

  assign m_valid_o = v2_q;
  assign m_data_o  = data2_q;
  assign m_sof_o   = sof2_q;
  assign m_eof_o   = eof2_q;

endmodule

`default_nettype wire

// File: rtl/ldpc_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ldpc_frame_ctrl
// Purpose  : Frame sequencer and codeword assembler around the 4320/360 LDPC
//            parity encoder: clears the encoder, feeds information bits with
//            their index, reads parity out 359..0 and emits one serial
//            codeword (4320 systematic + 360 parity bits) per frame.
// Options  : LDPC_FRAME_CNT_EN adds the 16-bit frame_cnt output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ldpc_frame_ctrl
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ldpc_frame_ctrl_if.slave  bus
`ifdef LDPC_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam logic [12:0] LAST_IDX = 13'(K_INFO - 1);
  localparam logic [8:0]  ADDR_TOP = 9'(N_PAR - 1);
  localparam logic [1:0]  CLR_LAST = 2'(CLR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [1:0]  clr_q, clr_d;

  logic in_info, in_par, accept;

  assign in_info = (state_q == INFO);
  assign in_par  = (state_q == PAR);
  assign accept  = in_info & bus.s_valid;

  // State, bit-index, parity-address and clear-length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR;
      cnt_q   <= '0;
      addr_q  <= ADDR_TOP;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state logic: CLR -> INFO -> FLUSH -> PAR -> CLR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLR: begin
        cnt_d  = '0;
        addr_d = ADDR_TOP;
        if (clr_q == CLR_LAST) begin
          clr_d   = '0;
          state_d = INFO;
        end else begin
          clr_d = clr_q + 2'd1;
        end
      end
      INFO: begin
        // Counter lands on K_INFO after the last bit and stays there
        if (bus.s_valid) begin
          cnt_d = cnt_q + 13'd1;
          if (cnt_q == LAST_IDX) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = PAR;
      end
      PAR: begin
        if (addr_q == 9'd0) begin
          addr_d  = ADDR_TOP;
          cnt_d   = '0;
          state_d = CLR;
        end else begin
          addr_d = addr_q - 9'd1;
        end
      end
      default: state_d = CLR;
    endcase
  end

  assign bus.s_ready       = in_info;
  assign bus.enc_rst_n     = (state_q != CLR);
  assign bus.enc_din_valid = accept;
  assign bus.enc_din       = in_info & bus.s_data;
  assign bus.enc_counter   = cnt_q;
  assign bus.enc_out_addr  = addr_q;
  assign bus.enc_check     = in_par;

  ldpc_out_pipe u_out_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_valid_i (accept | in_par),
    .sys_bit_i    (bus.s_data),
    .par_sel_i    (in_par),
    .sof_i        (accept & (cnt_q == 13'd0)),
    .eof_i        (in_par & (addr_q == 9'd0)),
    .enc_dout_i   (bus.enc_dout),
    .m_valid_o    (bus.m_valid),
    .m_data_o     (bus.m_data),
    .m_sof_o      (bus.m_sof),
    .m_eof_o      (bus.m_eof)
  );

`ifdef LDPC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter, stepped by each emitted end-of-frame marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (bus.m_eof) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldpc_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ldpc_frame_ctrl
// Purpose  : Directed self-checking bench for ldpc_frame_ctrl with a
//            behavioural accumulate-by-column-group encoder on enc_dout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ldpc_frame_ctrl;
  import ldpc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ldpc_frame_ctrl_if bus ();

`ifdef LDPC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  ldpc_frame_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LDPC_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural encoder: parity[a] accumulates info bits whose index mod GROUP is a
  logic [N_PAR-1:0] enc_acc;
  always @(posedge clk) begin : enc_model
    int ei;
    ei = int'(bus.enc_counter) % GROUP;
    if (!bus.enc_rst_n) enc_acc <= '0;
    else if (bus.enc_din_valid) enc_acc[ei] <= enc_acc[ei] ^ bus.enc_din;
    bus.enc_dout <= bus.enc_check ? enc_acc[bus.enc_out_addr] : 1'b0;
  end

  // Monitor: sampled on the falling edge, away from the active edge
  logic [2:0] out_q[$];
  int         out_cyc[$];
  int         acc_cyc[$];
  int         par_cyc_q[$];
  int         eof_seen = 0, addr_err = 0, last_gap = 0, fall_cyc = 0, exp_addr = 359;
  logic       prev_ready = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) exp_addr = 359;
    if (bus.s_valid && bus.s_ready) acc_cyc.push_back(cyc);
    if (bus.enc_check) begin
      if (int'(bus.enc_out_addr) != exp_addr) addr_err++;
      if (bus.enc_out_addr == 9'd359) par_cyc_q.push_back(cyc);
      exp_addr = (exp_addr == 0) ? 359 : exp_addr - 1;
    end
    if (bus.m_valid) begin
      out_q.push_back({bus.m_sof, bus.m_eof, bus.m_data});
      out_cyc.push_back(cyc);
    end
    if (bus.m_eof) eof_seen++;
    if (prev_ready && !bus.s_ready) fall_cyc = cyc;
    if (!prev_ready && bus.s_ready) last_gap = cyc - fall_cyc;
    prev_ready = bus.s_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    out_q.delete(); out_cyc.delete(); acc_cyc.delete(); par_cyc_q.delete();
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_s_ready"},   32'(bus.s_ready), 0);
    chk({p, "_enc_rst_n"}, 32'(bus.enc_rst_n), 0);
    chk({p, "_din_valid"}, 32'(bus.enc_din_valid), 0);
    chk({p, "_din"},       32'(bus.enc_din), 0);
    chk({p, "_counter"},   32'(bus.enc_counter), 0);
    chk({p, "_out_addr"},  32'(bus.enc_out_addr), 359);
    chk({p, "_check"},     32'(bus.enc_check), 0);
    chk({p, "_m_bus"},     32'({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eof}), 0);
`ifdef LDPC_FRAME_CNT_EN
    chk({p, "_frame_cnt"}, 32'(frame_cnt), 0);
`endif
  endtask

  // Reset asserted mid-clock, held 3 cycles, released just after a rising edge
  task automatic do_reset(input string p);
    @(posedge clk); #3;
    bus.s_valid = 1'b0; bus.s_data = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals(p);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = b;
    while (!bus.s_ready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) chk("ready_timeout", 32'(t), 0);
  endtask

  // One idle source cycle; the bit index must not move during it
  task automatic gap();
    logic [12:0] c0;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    c0 = bus.enc_counter;
    @(negedge clk);
    chk("counter_hold", 32'(bus.enc_counter), 32'(c0));
  endtask

  task automatic send_frame(input logic [K_INFO-1:0] inf, input bit stall);
    for (int i = 0; i < K_INFO; i++) begin
      send_bit(inf[i]);
      if (stall && i != K_INFO - 1) gap();
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    chk("flush_counter", 32'(bus.enc_counter), K_INFO);
    chk("flush_ready",   32'(bus.s_ready), 0);
  endtask

  task automatic wait_eof(input int target);
    int t = 0;
    while (eof_seen < target && t < 2000) begin
      @(posedge clk); t++;
    end
    chk("eof_timeout", 32'(eof_seen >= target), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int f, input logic [K_INFO-1:0] inf);
    logic [N_PAR-1:0] p;
    logic exp_d;
    int ob = f * CW_LEN;
    int ab = f * K_INFO;
    int derr = 0, merr = 0, lerr = 0;
    p = '0;
    for (int i = 0; i < K_INFO; i++) p[i % GROUP] ^= inf[i];
    if (out_q.size() >= ob + CW_LEN && acc_cyc.size() >= ab + K_INFO && par_cyc_q.size() > f) begin
      for (int j = 0; j < CW_LEN; j++) begin
        exp_d = (j < K_INFO) ? inf[j] : p[N_PAR - 1 - (j - K_INFO)];
        if (out_q[ob + j][0] !== exp_d) derr++;
        if (out_q[ob + j][2] !== (j == 0)) merr++;
        if (out_q[ob + j][1] !== (j == CW_LEN - 1)) merr++;
        if (j < K_INFO) begin
          if (out_cyc[ob + j] - acc_cyc[ab + j] != 2) lerr++;
        end else if (out_cyc[ob + j] - par_cyc_q[f] != 2 + (j - K_INFO)) begin
          lerr++;
        end
      end
    end else begin
      derr = 1; merr = 1; lerr = 1;
    end
    chk({tag, "_data_errs"},    32'(derr), 0);
    chk({tag, "_marker_errs"},  32'(merr), 0);
    chk({tag, "_latency_errs"}, 32'(lerr), 0);
  endtask

  logic [K_INFO-1:0] info_zero, info_one, info_a, info_c;
  int snap;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 1'b0;
    info_zero = '0;
    info_one  = '0;
    info_one[0] = 1'b1;
    for (int i = 0; i < K_INFO; i++) begin
      info_a[i] = 1'($urandom_range(0, 1));
      info_c[i] = 1'($urandom_range(0, 1));
    end

    // Power-on reset: asynchronous assertion before the first clock edge
    #3 rst_n = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    @(posedge clk); #1 chk("clr_cycle2_ready", 32'(bus.s_ready), 0);
    @(posedge clk); #1 chk("clr_cycle3_ready", 32'(bus.s_ready), 0);
    @(posedge clk); #1 chk("info_ready_rise",  32'(bus.s_ready), 1);

    // All-zero frame
    send_frame(info_zero, 1'b0);
    wait_eof(1);
    chk("zero_len", 32'(out_q.size()), CW_LEN);
    check_frame("zero", 0, info_zero);
    chk("zero_addr_seq", 32'(addr_err), 0);

    // Single one at index 0: only parity address 0 (last parity bit) is set
    clear_mon();
    send_frame(info_one, 1'b0);
    wait_eof(2);
    chk("one_len", 32'(out_q.size()), CW_LEN);
    check_frame("one", 0, info_one);
    if (out_q.size() >= CW_LEN) begin
      chk("one_sys0",     32'(out_q[0][0]), 1);
      chk("one_par_addr0", 32'(out_q[CW_LEN-1][0]), 1);
      chk("one_par_addr1", 32'(out_q[CW_LEN-2][0]), 0);
    end

    // Stalled source, same data: same codeword, gaps mirrored at latency 2
    clear_mon();
    send_frame(info_one, 1'b1);
    wait_eof(3);
    chk("stall_len", 32'(out_q.size()), CW_LEN);
    check_frame("stall", 0, info_one);

    // Back-to-back frames after reset: random A then all-zero B
    do_reset("rst2");
    snap = eof_seen;
    send_frame(info_a, 1'b0);
    send_frame(info_zero, 1'b0);
    wait_eof(snap + 2);
    chk("b2b_len", 32'(out_q.size()), 2 * CW_LEN);
    check_frame("frameA", 0, info_a);
    check_frame("frameB", 1, info_zero);
    chk("b2b_ready_gap", 32'(last_gap), 364);
`ifdef LDPC_FRAME_CNT_EN
    chk("frame_cnt_two", 32'(frame_cnt), 2);
`endif
    chk("b2b_addr_seq", 32'(addr_err), 0);

    // Reset mid-frame at bit index 2000: no eof, next frame clean
    for (int i = 0; i < 2000; i++) send_bit(info_a[i]);
    @(posedge clk); #1;
    chk("mid_counter", 32'(bus.enc_counter), 2000);
    bus.s_valid = 1'b0;
    snap = eof_seen;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (400) @(posedge clk);
    #1 chk("mid_no_eof", 32'(eof_seen), 32'(snap));
    send_frame(info_c, 1'b0);
    wait_eof(snap + 1);
    chk("post_eof_count", 32'(eof_seen), 32'(snap + 1));
    chk("post_len", 32'(out_q.size()), CW_LEN);
    check_frame("post", 0, info_c);
    chk("post_addr_seq", 32'(addr_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ldpc_frame_ctrl.md
# ldpc_frame_ctrl

Frame sequencer and codeword assembler that sits directly around the 4320/360 LDPC parity encoder. It accepts a serial stream of information bits and drives the encoder's `counter`, `din_valid`, `din`, `out_addr` and `data_valid_check` inputs. It clears the encoder between frames and emits one serial codeword per frame: 4320 systematic bits followed by 360 parity bits, with frame markers for the downstream mapper.

## Interface
- `K_INFO`, 4320: information bits per frame; must be a multiple of `GROUP`.
- `N_PAR`, 360: parity bits per frame.
- `GROUP`, 360: encoder column-group size.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s_valid` input 1: information bit present.
- `s_data` input 1: information bit.
- `s_ready` output 1: bit accepted when `s_valid && s_ready`.
- `enc_rst_n` output 1: synchronous clear to the encoder, active-low.
- `enc_din_valid` output 1: to encoder `din_valid`.
- `enc_din` output 1: to encoder `din`.
- `enc_counter` output 13: to encoder `counter`; the information-bit index.
- `enc_out_addr` output 9: to encoder `out_addr`.
- `enc_check` output 1: to encoder `data_valid_check`.
- `enc_dout` input 1: encoder parity output, registered inside the encoder.
- `m_valid` output 1: codeword bit valid. There is no backpressure.
- `m_data` output 1: codeword bit.
- `m_sof` output 1: high with the first systematic bit.
- `m_eof` output 1: high with the last parity bit.
- `frame_cnt` output 16: completed frames. Present only with `LDPC_FRAME_CNT_EN`.

## Operation
- FSM states: CLR, INFO, FLUSH, PAR.
- **CLR**, 3 cycles:
  - `enc_rst_n`=0, `enc_counter`=0, `s_ready`=0.
  - The encoder's address register and ROM prime group 0 during these cycles.
  - Go to INFO.
- **INFO**:
  - `s_ready`=1.
  - `enc_din_valid` = `s_valid`, combinational.
  - `enc_din` = `s_data`.
  - `enc_counter` is the index of the bit presented. It increments after each accepted bit and holds while `s_valid`=0.
  - When the bit at index `K_INFO`-1 is accepted, go to FLUSH.
- **FLUSH**, 1 cycle:
  - `s_ready`=0, `enc_din_valid`=0.
  - The last XOR commits in the encoder during this cycle.
  - `enc_counter` = `K_INFO` and holds there until CLR.
- **PAR**, `N_PAR` cycles:
  - `enc_check`=1.
  - `enc_out_addr` counts 359 down to 0, one per cycle.
  - After the cycle with address 0, go to CLR.
- Systematic bits are output in acceptance order. Parity bits are output in `enc_out_addr` order, 359 first.
- `m_sof` = first accepted bit of a frame. `m_eof` = parity slot with address 0.
- Frame length on `m_valid` is exactly `K_INFO`+`N_PAR` = 4680 bits.
- `enc_counter` is exactly 13 bits wide. `K_INFO` ≤ 8191 is required.

## Timing
- Reset values while `rst_n` is low:
  - `s_ready`=0, `enc_rst_n`=0, `enc_din_valid`=0, `enc_din`=0.
  - `enc_counter`=0, `enc_out_addr`=359, `enc_check`=0.
  - `m_valid`=0, `m_data`=0, `m_sof`=0, `m_eof`=0, `frame_cnt`=0.
  - FSM = CLR.
- Release from reset enters a full 3-cycle CLR.
- Output latency is 2 cycles for both bit types:
  - A bit accepted at cycle t appears on `m_*` at t+2.
  - A parity address issued at t gives `enc_dout` at t+1, which is registered to `m_data` at t+2.
- Gaps on `s_valid` produce identical gaps on `m_valid`.
- Between frames `s_ready` is low for 364 cycles: FLUSH (1) + PAR (360) + CLR (3).
- Frame overhead makes no gap in parity output. `m_eof` leads the next frame's `m_sof` by at least 4 cycles.
- Reset mid-frame: the frame is abandoned and no `m_eof` is produced. The next frame starts cleanly after CLR.
- `s_valid` while `s_ready`=0 is ignored. Bits are not lost; the source holds them.

## Configuration
- `LDPC_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments on the cycle `m_eof` is asserted and wraps from 65535 to 0.
  - Reset clears it.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `ldpc_pkg` holds:
  - constants `K_INFO`, `N_PAR`, `GROUP`, `CLR_CYCLES`=3;
  - the FSM state enum;
  - `CW_LEN`=`K_INFO`+`N_PAR`.
- Sub-module `ldpc_out_pipe` is a 2-stage alignment pipe.
  - Inputs: slot valid, systematic bit, parity-select, `sof`, `eof`, `enc_dout`.
  - Outputs: `m_valid`, `m_data`, `m_sof`, `m_eof`, in fixed latency order.
- The encoder itself is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst_n`=0 mid-clock → all outputs take their reset values asynchronously. After release, `s_ready` rises on the 4th cycle.
- **All-zero frame:** 4320 zeros back-to-back → 4680 `m_valid` bits, all 0; `m_sof` on output 1, `m_eof` on output 4680; `enc_out_addr` sequence 359..0.
- **Single one:** bit index 0 = 1, others 0 → output bits 4321–4680 equal the golden encoder-model parity for the group-0 column; systematic bits are echoed at latency 2.
- **Stalled source:** `s_valid` alternates 1/0 with the same data as the single-one test → identical codeword bits; `enc_counter` holds during gaps; `m_valid` gaps mirror the input.
- **Back-to-back frames:** random frame A then all-zero frame B → B's parity is all 0, proving the CLR clear works; `s_ready` is low for exactly 364 cycles between frames. With `LDPC_FRAME_CNT_EN` defined, `frame_cnt`=2.
- **Reset mid-frame:** `rst_n` pulsed low at `enc_counter`=2000 → no `m_eof` for that frame; the following full frame matches the golden model.
